mpu_prog_mem: RTL and testbench

MPU_PROG_MEM -- requirements
Module: mpu_prog_mem

---
 rtl/mpu_prog_mem.sv | 185 ++++++++++++++++++
 tb/tb_mpu_prog_mem.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_prog_mem.sv
// Byte-wide MPU program memory: four-phase instruction fetch port plus a streaming
// load port that halts the MPU while loading. Optional define: MPU_PMEM_BOUNDS_EN.
module mpu_prog_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [11:0]           fetch_addr,
  output logic                  fetch_ack,
  output logic [7:0]            fetch_data,
  input  logic                  load_en,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  output logic                  load_ready,
  output logic                  halt_req,
  output logic [DEPTH_LOG2:0]   load_cnt
`ifdef MPU_PMEM_BOUNDS_EN
  ,
  output logic                  pmem_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LP_CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LP_CNT_ONE = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = DEPTH_LOG2'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_ACK   = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_hi;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic                  r_ack;
  logic [7:0]            r_data;
  logic                  r_ready;
  logic                  r_halt;
  logic                  r_err;
  logic [7:0]            r_mem [0:DEPTH-1];

  logic                  w_we;
  logic                  w_addr_hi;
  logic [7:0]            w_rd_byte;

`ifdef MPU_PMEM_BOUNDS_EN
  assign w_addr_hi = |fetch_addr[11:DEPTH_LOG2];
`else
  // Upper address bits are deliberately ignored so fetches wrap modulo depth.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = |fetch_addr[11:DEPTH_LOG2];
  assign w_addr_hi        = 1'b0;
`endif

  // Write strobe: only while loading and not on the exit cycle.
  always_comb begin
    w_we = 1'b0;
    if ((r_state == S_LOAD) && load_en && load_valid) begin
      w_we = 1'b1;
    end else begin
      w_we = 1'b0;
    end
  end

  // Read byte for the captured fetch, blanked for out-of-range addresses.
  always_comb begin
    w_rd_byte = 8'h00;
    if (r_hi) begin
      w_rd_byte = 8'h00;
    end else begin
      w_rd_byte = r_mem[r_idx];
    end
  end

  // Control FSM with registered fetch/load handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hi    <= 1'b0;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_data  <= 8'h00;
      r_ready <= 1'b0;
      r_halt  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack  <= 1'b0;
          r_data <= 8'h00;
          r_err  <= 1'b0;
          if (load_en) begin
            r_state <= S_LOAD;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_halt  <= 1'b1;
          end else if (fetch_req) begin
            r_state <= S_LATCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LATCH: begin
          r_idx   <= fetch_addr[DEPTH_LOG2-1:0];
          r_hi    <= w_addr_hi;
          r_state <= S_ACK;
        end
        S_ACK: begin
          // The ack tracks fetch_req so it drops on the same edge we leave ACK.
          if (fetch_req) begin
            r_ack   <= 1'b1;
            r_data  <= w_rd_byte;
            r_err   <= r_hi;
            r_state <= S_ACK;
          end else begin
            r_ack   <= 1'b0;
            r_data  <= 8'h00;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (!load_en) begin
            r_ready <= 1'b0;
            r_halt  <= 1'b0;
            r_state <= S_IDLE;
          end else if (load_valid) begin
            r_wptr <= r_wptr + LP_PTR_ONE;
            if (r_cnt != LP_CNT_MAX) begin
              r_cnt <= r_cnt + LP_CNT_ONE;
            end else begin
              r_cnt <= r_cnt;
            end
          end else begin
            r_state <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_data  <= 8'h00;
          r_ready <= 1'b0;
          r_halt  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Program storage, cleared to zero by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_we) begin
      r_mem[r_wptr] <= load_data;
    end else begin
      r_mem[r_wptr] <= r_mem[r_wptr];
    end
  end

  assign fetch_ack  = r_ack;
  assign fetch_data = r_data;
  assign load_ready = r_ready;
  assign halt_req   = r_halt;
  assign load_cnt   = r_cnt;

`ifdef MPU_PMEM_BOUNDS_EN
  assign pmem_err = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_err;
`endif

endmodule

// File: tb/tb_mpu_prog_mem.sv
// Self-checking bench for mpu_prog_mem: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_mpu_prog_mem;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst_n;
  logic         fetch_req;
  logic [11:0]  fetch_addr;
  logic         fetch_ack;
  logic [7:0]   fetch_data;
  logic         load_en;
  logic         load_valid;
  logic [7:0]   load_data;
  logic         load_ready;
  logic         halt_req;
  logic [DL2:0] load_cnt;
`ifdef MPU_PMEM_BOUNDS_EN
  logic         pmem_err;
`endif

  mpu_prog_mem #(.DEPTH_LOG2(DL2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .halt_req   (halt_req),
    .load_cnt   (load_cnt)
`ifdef MPU_PMEM_BOUNDS_EN
    ,
    .pmem_err   (pmem_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: loading flag, fetch age in edges since acceptance, memory array.
  logic [7:0]  m_mem [DEPTH];
  bit          m_loading;
  int          m_age;
  int          m_cnt;
  int          m_ptr;
  bit          m_ack;
  logic [7:0]  m_data;
  logic [11:0] m_addr;
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= 8'h00;
      m_loading <= 1'b0; m_age <= 0; m_cnt <= 0; m_ptr <= 0;
      m_ack <= 1'b0; m_data <= 8'h00; m_addr <= 12'h000; m_err <= 1'b0;
    end else if (m_loading) begin
      if (!load_en) m_loading <= 1'b0;
      else if (load_valid) begin
        m_mem[m_ptr] <= load_data;
        m_ptr <= (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt <= m_cnt + 1;
      end
    end else if (m_age == 0) begin
      if (load_en) begin
        m_loading <= 1'b1; m_cnt <= 0; m_ptr <= 0;
      end else if (fetch_req) m_age <= 1;
    end else if (m_age == 1) begin
      m_addr <= fetch_addr;
      m_age  <= 2;
    end else if (fetch_req) begin
      m_ack <= 1'b1;
`ifdef MPU_PMEM_BOUNDS_EN
      m_err  <= (m_addr >= 12'(DEPTH));
      m_data <= (m_addr >= 12'(DEPTH)) ? 8'h00 : m_mem[int'(m_addr) % DEPTH];
`else
      m_data <= m_mem[int'(m_addr) % DEPTH];
`endif
      m_age <= m_age + 1;
    end else begin
      m_ack <= 1'b0; m_data <= 8'h00; m_err <= 1'b0; m_age <= 0;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    chk("ack", fetch_ack, m_ack);
    chk("data", fetch_data, m_data);
    chk("ready", load_ready, m_loading);
    chk("halt", halt_req, m_loading);
    chk("cnt", load_cnt, m_cnt);
`ifdef MPU_PMEM_BOUNDS_EN
    chk("err", pmem_err, m_err);
`endif
  end

  logic [7:0] ld_buf [32];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int n, output int cnt_seen);
    load_en = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = ld_buf[i];
      tick();
      chk("halt_during_load", halt_req, 1'b1);
    end
    cnt_seen   = int'(load_cnt);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    load_en    = 1'b0;
    tick();
    load_valid = 1'b0;
    chk("halt_after_load", halt_req, 1'b0);
  endtask

  task automatic wait_ack(input int limit, output int ticks);
    ticks = 0;
    while (fetch_ack !== 1'b1 && ticks < limit) begin
      tick();
      ticks++;
    end
    if (fetch_ack !== 1'b1) begin
      n_total++;
      n_bad++;
      $display("FAIL ack_timeout actual=0 required=1 after %0d cycles", ticks);
    end
  endtask

  task automatic do_fetch(input logic [11:0] addr, input int hold, output logic [7:0] data, output int lat);
    int t;
    int highs;
    fetch_addr = addr;
    fetch_req  = 1'b1;
    wait_ack(20, t);
    lat   = t - 1;
    data  = fetch_data;
    highs = 1;
    repeat (hold - 1) begin
      tick();
      if (fetch_ack === 1'b1) highs++;
    end
    chk("ack_hold", highs, hold);
    fetch_req = 1'b0;
    tick();
    chk("ack_fall", fetch_ack, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    int lat;
    int cnt;
    int t;

    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 12'h000;
    load_en = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    #1;
    chk("rst_ack", fetch_ack, 1'b0);
    chk("rst_cnt", load_cnt, 5'd0);
    chk("rst_halt", halt_req, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Three-byte load then fetch of address 1.
    ld_buf[0] = 8'h11; ld_buf[1] = 8'h22; ld_buf[2] = 8'h33;
    do_load(3, cnt);
    chk("cnt3", cnt, 3);
    do_fetch(12'h001, 1, d, lat);
    chk("lat_a1", lat, 2);
    chk("data_a1", d, 8'h22);
    do_fetch(12'h003, 1, d, lat);
    chk("exit_byte_not_written", d, 8'h00);
    do_fetch(12'h002, 5, d, lat);
    chk("data_hold5", d, 8'h33);

    // Seventeen bytes wrap onto index 0.
    for (int i = 0; i < 17; i++) ld_buf[i] = 8'(i);
    do_load(17, cnt);
    chk("cnt_sat", cnt, 16);
    do_fetch(12'h000, 2, d, lat);
    chk("data_wrap", d, 8'h10);
    do_fetch(12'h013, 1, d, lat);
`ifdef MPU_PMEM_BOUNDS_EN
    chk("data_oob", d, 8'h00);
`else
    chk("data_alias", d, 8'h03);
`endif

    // Simultaneous fetch_req and load_en: load wins, fetch served afterwards.
    fetch_addr = 12'h002; fetch_req = 1'b1; load_en = 1'b1;
    tick();
    chk("load_prio", load_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 8'hA0 + 8'(i);
      tick();
      chk("no_ack_in_load", fetch_ack, 1'b0);
    end
    load_valid = 1'b0; load_en = 1'b0;
    wait_ack(20, t);
    chk("deferred_lat", t, 4);
    chk("deferred_data", fetch_data, 8'h02);
    fetch_req = 1'b0;
    tick();

    // Reset pulse in the middle of an acknowledged fetch.
    fetch_addr = 12'h001; fetch_req = 1'b1;
    wait_ack(20, t);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", fetch_ack, 1'b0);
    chk("rst_mid_data", fetch_data, 8'h00);
    fetch_req = 1'b0;
    tick();
    rst_n = 1'b1;
    do_fetch(12'h001, 1, d, lat);
    chk("lat_after_rst", lat, 2);
    chk("data_after_rst", d, 8'h00);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) load_en = ~load_en;
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 8'($urandom);
      if (!fetch_req) fetch_addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) fetch_req = ~fetch_req;
      tick();
    end
    load_en = 1'b0; load_valid = 1'b0; fetch_req = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
